// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: DEPTH-entry {addr, inst} FIFO feeding a registered IF/ID stage,
// with valid/ready fetch handshake, flush, empty-queue bypass and fill-level reporting.
module if_prefetch_queue #(
   parameter int unsigned                  InstDataBus = 32,
   parameter int unsigned                  InstAddrBus = 32,
   parameter int unsigned                  HoldFlagBus = 3,
   parameter int unsigned                  Depth       = 4,
   parameter logic [HoldFlagBus-1:0]       IfHoldLevel = 3'd1,
   parameter logic [InstDataBus-1:0]       NopInst     = 32'h00000001
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_fetch_valid,
   input  logic [InstDataBus-1:0]          i_fetch_data,
   input  logic [InstAddrBus-1:0]          i_fetch_addr,
   output logic                            o_fetch_ready,
   input  logic [HoldFlagBus-1:0]          i_hold_flag,
   input  logic                            i_flush,
   output logic                            o_inst_valid,
   output logic [InstDataBus-1:0]          o_inst_data,
   output logic [InstAddrBus-1:0]          o_inst_addr,
   output logic [$clog2(Depth):0]          o_level
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned EntW = InstAddrBus + InstDataBus;
   localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

   logic [EntW-1:0]        mem_q [Depth];
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic                   valid_q, valid_d;
   logic [InstDataBus-1:0] data_q, data_d;
   logic [InstAddrBus-1:0] addr_q, addr_d;

   logic                   hold_en;
   logic                   push;
   logic                   pop;
   logic                   wr_en;
   logic [InstAddrBus-1:0] head_addr;
   logic [InstDataBus-1:0] head_data;

   // Ready depends only on registered occupancy, so a full queue refuses even while popping.
   assign o_fetch_ready = (count_q != FullCnt);
   assign hold_en       = (i_hold_flag >= IfHoldLevel);
   assign push          = i_fetch_valid & o_fetch_ready & ~i_flush;
   assign {head_addr, head_data} = mem_q[rd_ptr_q];

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      valid_d  = valid_q;
      data_d   = data_q;
      addr_d   = addr_q;
      pop      = 1'b0;
      wr_en    = 1'b0;
      if (i_flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         valid_d  = 1'b0;
         data_d   = NopInst;
         addr_d   = '0;
      end else begin
         // A push goes to the FIFO unless it can bypass straight into the empty output stage.
         wr_en = push & (hold_en | (count_q != '0));
         if (!hold_en) begin
            if (count_q != '0) begin
               pop      = 1'b1;
               valid_d  = 1'b1;
               data_d   = head_data;
               addr_d   = head_addr;
               rd_ptr_d = rd_ptr_q + PtrW'(1);
            end else if (push) begin
               valid_d = 1'b1;
               data_d  = i_fetch_data;
               addr_d  = i_fetch_addr;
            end else begin
               valid_d = 1'b0;
               data_d  = NopInst;
               addr_d  = '0;
            end
         end
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         count_d = count_q + CntW'(wr_en) - CntW'(pop);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         valid_q  <= 1'b0;
         data_q   <= NopInst;
         addr_q   <= '0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         addr_q   <= addr_d;
      end
   end

   // Storage needs no reset: entries are only read once count_q marks them written.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {i_fetch_addr, i_fetch_data};
      end
   end

   assign o_inst_valid = valid_q;
   assign o_inst_data  = data_q;
   assign o_inst_addr  = addr_q;
   assign o_level      = count_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: a queue of expected {addr, inst} entries is pushed
// on accepted fetches and popped whenever the output stage is expected to advance.
module tb_if_prefetch_queue;

   localparam int unsigned Depth = 4;
   localparam logic [31:0] Nop   = 32'h00000001;

   logic        clk;
   logic        rst_n;
   logic        fetch_valid;
   logic [31:0] fetch_data;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic [2:0]  hold_flag;
   logic        flush;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_addr;
   logic [2:0]  level;

   int unsigned n_tests;
   int unsigned n_fail;

   logic [63:0] exp_q[$];
   logic        cur_valid;
   logic [31:0] cur_data;
   logic [31:0] cur_addr;

   if_prefetch_queue #(
      .Depth (Depth)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_fetch_valid (fetch_valid),
      .i_fetch_data  (fetch_data),
      .i_fetch_addr  (fetch_addr),
      .o_fetch_ready (fetch_ready),
      .i_hold_flag   (hold_flag),
      .i_flush       (flush),
      .o_inst_valid  (inst_valid),
      .o_inst_data   (inst_data),
      .o_inst_addr   (inst_addr),
      .o_level       (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag);
      check({tag, "_valid"}, 64'(inst_valid), 64'(cur_valid));
      check({tag, "_data"},  64'(inst_data),  64'(cur_data));
      check({tag, "_addr"},  64'(inst_addr),  64'(cur_addr));
      check({tag, "_level"}, 64'(level),      64'(exp_q.size()));
   endtask

   // Drive one cycle of stimulus, update the model at the edge, then compare.
   task automatic step(input logic fv, input logic [31:0] d, input logic [31:0] a,
                       input logic [2:0] hf, input logic fl, input string tag);
      logic rdy;
      logic acc;
      logic [63:0] e;
      fetch_valid = fv;
      fetch_data  = d;
      fetch_addr  = a;
      hold_flag   = hf;
      flush       = fl;
      rdy = (exp_q.size() != Depth);
      acc = fv & rdy & ~fl;
      #1;
      check({tag, "_ready"}, 64'(fetch_ready), 64'(rdy));
      @(posedge clk);
      #1;
      if (fl) begin
         exp_q.delete();
         cur_valid = 1'b0;
         cur_data  = Nop;
         cur_addr  = '0;
      end else begin
         if (acc) exp_q.push_back({a, d});
         if (hf < 3'd1) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               cur_valid = 1'b1;
               cur_addr  = e[63:32];
               cur_data  = e[31:0];
            end else begin
               cur_valid = 1'b0;
               cur_data  = Nop;
               cur_addr  = '0;
            end
         end
      end
      fetch_valid = 1'b0;
      check_out(tag);
   endtask

   initial begin
      logic [31:0] last_addr;
      n_tests     = 0;
      n_fail      = 0;
      fetch_valid = 1'b0;
      fetch_data  = '0;
      fetch_addr  = '0;
      hold_flag   = '0;
      flush       = 1'b0;
      cur_valid   = 1'b0;
      cur_data    = Nop;
      cur_addr    = '0;
      rst_n       = 1'b0;

      // 1. reset then idle
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_valid", 64'(inst_valid), 64'd0);
      check("rst_data",  64'(inst_data),  64'(Nop));
      check("rst_addr",  64'(inst_addr),  64'd0);
      check("rst_level", 64'(level),      64'd0);
      step(1'b0, '0, '0, 3'd0, 1'b0, "idle");
      check("idle_ready", 64'(fetch_ready), 64'd1);

      // 2. bypass into the empty output stage
      step(1'b1, 32'h00500093, 32'h80, 3'd0, 1'b0, "byp");
      check("byp_valid", 64'(inst_valid), 64'd1);
      check("byp_addr",  64'(inst_addr),  64'h80);
      check("byp_data",  64'(inst_data),  64'h00500093);
      check("byp_level", 64'(level),      64'd0);
      step(1'b0, '0, '0, 3'd0, 1'b0, "byp_idle");

      // 3. fill under hold; fifth push refused
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 32'h1000_0000 | (i * 4), i * 4, 3'd2, 1'b0, "fill");
      end
      check("full_level", 64'(level),       64'd4);
      check("full_ready", 64'(fetch_ready), 64'd0);
      check("full_valid", 64'(inst_valid),  64'd0);
      // full queue refuses a push even while the release pops
      step(1'b1, 32'hdead_beef, 32'h99, 3'd0, 1'b0, "rel");
      check("rel_addr0", 64'(inst_addr), 64'h0);
      for (int i = 1; i < 4; i++) begin
         step(1'b0, '0, '0, 3'd0, 1'b0, "drain");
         check("drain_addr", 64'(inst_addr), 64'(i * 4));
      end
      step(1'b0, '0, '0, 3'd0, 1'b0, "drain_end");

      // 4. flush mid-stream with a same-cycle fetch
      step(1'b1, 32'h2000_0000, 32'h100, 3'd0, 1'b0, "pre_fl");
      for (int i = 1; i < 4; i++) begin
         step(1'b1, 32'h2000_0000 | (i * 4), 32'h100 + i * 4, 3'd1, 1'b0, "pre_fl_h");
      end
      check("pre_fl_level", 64'(level), 64'd3);
      step(1'b1, 32'hbad0_0000, 32'h200, 3'd0, 1'b1, "flush");
      check("fl_level", 64'(level),      64'd0);
      check("fl_valid", 64'(inst_valid), 64'd0);
      check("fl_data",  64'(inst_data),  64'(Nop));
      repeat (2) step(1'b0, '0, '0, 3'd0, 1'b0, "post_fl");

      // 5. wrap-around: two entries of backlog, then streaming push/pop
      step(1'b1, 32'h3000_0000, 32'h1000, 3'd3, 1'b0, "wrap_pre");
      step(1'b1, 32'h3000_0004, 32'h1004, 3'd3, 1'b0, "wrap_pre");
      last_addr = 32'h1000 - 4;
      for (int i = 2; i < 2 + 3 * Depth; i++) begin
         step(1'b1, 32'h3000_0000 | (i * 4), 32'h1000 + i * 4, 3'd0, 1'b0, "wrap");
         check("wrap_contig", 64'(inst_addr), 64'(last_addr + 4));
         last_addr = inst_addr;
      end
      repeat (3) step(1'b0, '0, '0, 3'd0, 1'b0, "wrap_drain");

      // 6. async reset between edges
      step(1'b1, 32'h4000_0000, 32'h2000, 3'd0, 1'b0, "ar_byp");
      step(1'b1, 32'h4000_0004, 32'h2004, 3'd1, 1'b0, "ar_h");
      step(1'b1, 32'h4000_0008, 32'h2008, 3'd1, 1'b0, "ar_h");
      check("ar_pre_level", 64'(level),      64'd2);
      check("ar_pre_valid", 64'(inst_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      cur_valid = 1'b0;
      cur_data  = Nop;
      cur_addr  = '0;
      check_out("ar");
      #1;
      rst_n = 1'b1;
      step(1'b0, '0, '0, 3'd0, 1'b0, "ar_idle");
      step(1'b1, 32'h5000_0000, 32'h3000, 3'd0, 1'b0, "ar_byp2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Parametrised successor to the IF/ID pipeline register. Decouples the instruction bus from decode with a DEPTH-entry FIFO of {addr, inst} pairs, followed by a registered IF/ID output stage.
- Adds valid/ready fetch handshake, flush on branch/jump, bypass on empty, and fill-level reporting.
- Sits between the PC/instruction-memory interface and the decode stage.

Parameters:
- InstDataBus, 32, instruction width.
- InstAddrBus, 32, instruction address width.
- HoldFlagBus, 3, pipeline hold flag width.
- Depth, 4, FIFO entries; power of two, >= 2.
- IfHoldLevel, 3'd1, hold_flag threshold at or above which the IF output stage freezes.
- NopInst, 32'h00000001, instruction emitted when the output stage holds no valid instruction.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_fetch_valid  in  1  fetch bus presents a valid instruction.
- i_fetch_data  in  InstDataBus  fetched instruction.
- i_fetch_addr  in  InstAddrBus  address of the fetched instruction.
- o_fetch_ready  out  1  queue accepts a push this cycle.
- i_hold_flag  in  HoldFlagBus  pipeline pause code.
- i_flush  in  1  discard all queued and output instructions (branch/jump taken).
- o_inst_valid  out  1  IF/ID output holds a real instruction.
- o_inst_data  out  InstDataBus  IF/ID instruction.
- o_inst_addr  out  InstAddrBus  IF/ID address.
- o_level  out  $clog2(Depth)+1  current FIFO occupancy, excluding the output register.

Behaviour:
- Reset (async, i_rst_n=0):
  - count, read pointer and write pointer = 0.
  - o_inst_valid=0, o_inst_data=NopInst, o_inst_addr=0.
  - o_fetch_ready=1 from the first cycle after release.
- hold_en = (i_hold_flag >= IfHoldLevel).
- push = i_fetch_valid & o_fetch_ready & ~i_flush.
- o_fetch_ready = (count != Depth). It is registered-state based and never depends on same-cycle pop; a full queue refuses a push even while popping.
- Output stage advance (hold_en=0, i_flush=0), evaluated at each rising edge:
  - count>0: output loads the FIFO head with valid=1, and the read pointer increments.
  - count==0 and push: bypass. Output loads i_fetch_data/i_fetch_addr with valid=1, and the FIFO is not written.
  - count==0 and no push: output loads NopInst, addr 0, valid=0.
  - count>0 and push: the head pops and the new entry is written at the tail; count unchanged.
- Hold (hold_en=1, i_flush=0):
  - Output registers keep their values.
  - A push is written into the FIFO, with no bypass.
  - count increments on push.
- Flush (i_flush=1, regardless of hold_en):
  - Next edge: count=0, both pointers = 0.
  - Output becomes NopInst, addr 0, valid=0.
  - The same-cycle fetch is dropped.
- Latency:
  - Empty queue, no hold: push at edge N appears on the outputs after edge N (1 cycle).
  - Otherwise: FIFO order strictly preserved.
- Pointers wrap modulo Depth. count range is 0..Depth; o_level = count.
- Data and address in the FIFO are stored unmodified at full width.
- No combinational path from i_hold_flag to o_fetch_ready.

Test Plan:
1. Reset then idle:
   - Stimulus: i_rst_n low, then high; no fetch.
   - Required: o_inst_valid=0, o_inst_data=32'h00000001, o_inst_addr=0, o_level=0, o_fetch_ready=1.
2. Bypass:
   - Stimulus: empty queue, hold=0; push {0x00000080, 0x00500093} for one cycle.
   - Required: next cycle o_inst_valid=1, o_inst_addr=0x80, o_inst_data=0x00500093; o_level stays 0.
3. Fill under hold:
   - Stimulus: hold_flag=3'd2 (>= IfHoldLevel); push 5 entries at addr 0x0,0x4,...,0x10.
   - Required: first 4 accepted; o_fetch_ready=0 with o_level=4 and the 5th not accepted; outputs unchanged. Release hold: outputs show 0x0,0x4,0x8,0xC on successive cycles.
4. Flush mid-stream:
   - Stimulus: o_level=3; assert i_flush together with i_fetch_valid.
   - Required: next cycle o_level=0, o_inst_valid=0, o_inst_data=NopInst; the pushed entry is absent afterwards.
5. Wrap-around:
   - Stimulus: continuous push/pop for 3×Depth instructions with an incrementing address.
   - Required: output address sequence is contiguous with no duplicates or gaps.
6. Async reset mid-operation:
   - Stimulus: o_level=2 and output valid; pulse i_rst_n low between clock edges.
   - Required: outputs go to reset values immediately, without waiting for a clock edge.
